// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types and default parameter values for the clock monitor.

package clk_mon_pkg;

  // Default configuration of the monitor.
  localparam int unsigned SyncStagesDef = 2;
  localparam int unsigned CntWDef       = 16;
  localparam int unsigned TimeoutDef    = 64;
  localparam int unsigned StartEdgesDef = 4;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StLock,
    StLost
  } clk_mon_state_t;

endpackage

// File: rtl/clk_mon_sync.sv
// clk_mon_sync: brings the generated clock into the clk domain through a flop chain,
// then a history flop, and flags each rising edge for one clk cycle.

module clk_mon_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk,
  output logic mon_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain plus history flop, all cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign mon_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_mon.sv
// clk_mon: consumer-side monitor for the master clock generator. Drives the
// generator enable, measures the generated clock period in clk cycles, declares
// lock after a run of start-up edges and raises a sticky loss-of-clock flag.
// Build macro CLK_MON_STATS_EN adds running min/max period statistics; without it
// period_min/period_max read 0 and stats_clr is ignored.

module clk_mon
  import clk_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDef,
  parameter int unsigned CNT_W       = CntWDef,
  parameter int unsigned TIMEOUT     = TimeoutDef,
  parameter int unsigned START_EDGES = StartEdgesDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_clk,
  input  logic             lost_clr,
  input  logic             stats_clr,
  output logic             gen_en,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
);

  // Start-up edge counter only has to reach START_EDGES-1; the next edge locks.
  localparam int unsigned EdgeW = (START_EDGES > 1) ? $clog2(START_EDGES) : 1;

  localparam logic [CNT_W-1:0] CntTimeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [EdgeW-1:0] EdgeLast   = EdgeW'(START_EDGES - 1);
  localparam logic [EdgeW-1:0] EdgeOne    = EdgeW'(1);

  // Elaboration-time parameter checks.
  if (SYNC_STAGES < 2) begin : gen_chk_sync
    $error("clk_mon: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 2 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : gen_chk_timeout
    $error("clk_mon: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
  end
  if (START_EDGES < 1) begin : gen_chk_edges
    $error("clk_mon: START_EDGES must be at least 1");
  end

  logic mon_edge;

  clk_mon_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .mon_clk (mon_clk),
    .mon_edge(mon_edge)
  );

  clk_mon_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EdgeW-1:0] edges_q, edges_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             gen_en_q, locked_q, lost_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             meas;

  // Period counter saturates rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

  // An edge in the same cycle as the timeout count wins over the timeout.
  assign timeout = (cnt_q == CntTimeout) && !mon_edge;

  // Next-state, counters and measurement; priority is en, then timeout, then edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edges_d  = edges_q;
    period_d = period_q;
    vld_d    = 1'b0;
    meas     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        edges_d = '0;
        if (en) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
          edges_d = '0;
        end else if (timeout) begin
          state_d = StLost;
          cnt_d   = '0;
          edges_d = '0;
        end else if (mon_edge) begin
          cnt_d = CntOne;
          if (edges_q == EdgeLast) begin
            state_d = StLock;
            edges_d = '0;
          end else begin
            edges_d = edges_q + EdgeOne;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StLock: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StLost;
          cnt_d   = '0;
        end else if (mon_edge) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          meas     = 1'b1;
          cnt_d    = CntOne;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StLost: begin
        cnt_d   = '0;
        edges_d = '0;
        if (lost_clr) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        edges_d = '0;
      end
    endcase
  end

  // State, counters and registered status outputs; reset drops gen_en immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      edges_q  <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      gen_en_q <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edges_q  <= edges_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      gen_en_q <= (state_d == StStart) || (state_d == StLock);
      locked_q <= (state_d == StLock);
      lost_q   <= (state_d == StLost);
    end
  end

  assign gen_en     = gen_en_q;
  assign locked     = locked_q;
  assign lost       = lost_q;
  assign period     = period_q;
  assign period_vld = vld_q;

`ifdef CLK_MON_STATS_EN
  logic [CNT_W-1:0] min_q, max_q;

  // Running extremes of reported periods; a clear discards a coincident measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (stats_clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (meas) begin
      if (cnt_q < min_q) begin
        min_q <= cnt_q;
      end
      if (cnt_q > max_q) begin
        max_q <= cnt_q;
      end
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`else
  logic unused_stats;

  assign unused_stats = ^{stats_clr, meas};
  assign period_min   = '0;
  assign period_max   = '0;
`endif

endmodule
